alu_mc: RTL and testbench

- Parametrised multi-cycle execute unit for the EX stage.
- Covers the single-cycle integer ops: add, sub, slt, sltu, and, nor, or, xor, sll, srl, sra, lui.
- Adds iterative MULT/MULTU/DIV/DIVU with a two-word (hi/lo) result.
- Valid/ready handshakes on both sides and a pipeline flush input, so the stage can stall on long ops.

---
 rtl/alu_mc.sv | 296 +++++++++++++++++++++++++++++
 tb/tb_alu_mc.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mc.sv
// -----------------------------------------------------------------------------
// alu_mc -- multi-cycle execute unit for the EX stage.
//
// Single-cycle integer ops (add/sub/slt/sltu/and/nor/or/xor/sll/srl/sra/lui)
// complete with latency 1. MULT/MULTU/DIV/DIVU iterate one bit per cycle over
// operand magnitudes (radix-2 shift-add / restoring divide) and finish with a
// two-word result after XLEN busy cycles (out_valid at accept+XLEN+1).
//
// Build option:
//   ALU_MC_FAST_MUL_EN  when defined, MULT/MULTU use a combinational
//                       XLEN x XLEN multiplier and retire with latency 1.
//                       Division is unaffected.
//
// Ports:
//   clk        rising-edge clock
//   resetn     synchronous active-low reset
//   flush      abort any op in flight (wins over accept and retire)
//   in_valid   op/operands presented
//   in_ready   unit idle, can accept an op
//   op         4-bit operation code
//   opr1       rs operand / shift amount source
//   opr2       rt operand / shifted value / lui immediate
//   out_valid  result valid
//   out_ready  consumer takes the result
//   res        result; low product / quotient for mul/div
//   res_hi     high product / remainder; 0 for simple ops
//   busy       iterative op in progress
// -----------------------------------------------------------------------------
module alu_mc #(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      op,
    input  logic [XLEN-1:0] opr1,
    input  logic [XLEN-1:0] opr2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] res,
    output logic [XLEN-1:0] res_hi,
    output logic            busy
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_SLT   = 4'd2;
    localparam logic [3:0] OP_SLTU  = 4'd3;
    localparam logic [3:0] OP_AND   = 4'd4;
    localparam logic [3:0] OP_NOR   = 4'd5;
    localparam logic [3:0] OP_OR    = 4'd6;
    localparam logic [3:0] OP_XOR   = 4'd7;
    localparam logic [3:0] OP_SLL   = 4'd8;
    localparam logic [3:0] OP_SRL   = 4'd9;
    localparam logic [3:0] OP_SRA   = 4'd10;
    localparam logic [3:0] OP_LUI   = 4'd11;
    localparam logic [3:0] OP_MULT  = 4'd12;
    localparam logic [3:0] OP_MULTU = 4'd13;
    localparam logic [3:0] OP_DIV   = 4'd14;
    localparam logic [3:0] OP_DIVU  = 4'd15;

    localparam logic [SHW-1:0] CNT_LAST = SHW'(XLEN - 1);

    // ---------------------------------------------------------------- state
    logic [1:0]      state_q,   state_d;
    logic [SHW-1:0]  cnt_q,     cnt_d;
    logic            is_div_q,  is_div_d;
    logic            neg_res_q, neg_res_d;   // negate product / quotient
    logic            neg_rem_q, neg_rem_d;   // negate remainder
    logic            dbz_q,     dbz_d;       // divide by zero
    logic [XLEN-1:0] dvd_q,     dvd_d;       // raw dividend for div-by-zero
    logic [XLEN-1:0] acc_hi_q,  acc_hi_d;    // partial product hi / remainder
    logic [XLEN-1:0] acc_lo_q,  acc_lo_d;    // multiplier bits / quotient bits
    logic [XLEN-1:0] mcand_q,   mcand_d;     // multiplicand / divisor magnitude
    logic [XLEN-1:0] res_q,     res_d;
    logic [XLEN-1:0] res_hi_q,  res_hi_d;

    // ------------------------------------------------------ input decoding
    logic            is_muldiv;
    logic            is_div_op;
    logic            is_signed_op;
    logic            a_neg, b_neg;
    logic [XLEN-1:0] a_mag, b_mag;
    logic [XLEN:0]   diff;
    logic [SHW-1:0]  shamt;
    logic            lt_s;
    logic [XLEN-1:0] simple_res;

    always_comb begin
        is_muldiv    = (op == OP_MULT) || (op == OP_MULTU) ||
                       (op == OP_DIV)  || (op == OP_DIVU);
        is_div_op    = (op == OP_DIV)  || (op == OP_DIVU);
        is_signed_op = (op == OP_MULT) || (op == OP_DIV);
        a_neg        = is_signed_op & opr1[XLEN-1];
        b_neg        = is_signed_op & opr2[XLEN-1];
        a_mag        = a_neg ? -opr1 : opr1;
        b_mag        = b_neg ? -opr2 : opr2;
        // One subtractor serves SUB, SLTU (borrow out) and SLT (sign).
        diff         = {1'b0, opr1} - {1'b0, opr2};
        shamt        = opr1[SHW-1:0];
        // Signs differ: the negative operand is smaller. Signs equal: no
        // overflow is possible, so the difference sign decides.
        lt_s         = (opr1[XLEN-1] != opr2[XLEN-1]) ? opr1[XLEN-1] : diff[XLEN-1];
    end

    always_comb begin
        simple_res = '0;
        case (op)
            OP_ADD:  simple_res = opr1 + opr2;
            OP_SUB:  simple_res = diff[XLEN-1:0];
            OP_SLT:  simple_res = {{(XLEN-1){1'b0}}, lt_s};
            OP_SLTU: simple_res = {{(XLEN-1){1'b0}}, diff[XLEN]};
            OP_AND:  simple_res = opr1 & opr2;
            OP_NOR:  simple_res = ~(opr1 | opr2);
            OP_OR:   simple_res = opr1 | opr2;
            OP_XOR:  simple_res = opr1 ^ opr2;
            OP_SLL:  simple_res = opr2 << shamt;
            OP_SRL:  simple_res = opr2 >> shamt;
            OP_SRA:  simple_res = $signed(opr2) >>> shamt;
            OP_LUI:  simple_res = {opr2[XLEN/2-1:0], {(XLEN/2){1'b0}}};
            default: simple_res = '0;
        endcase
    end

`ifdef ALU_MC_FAST_MUL_EN
    logic [2*XLEN-1:0] fm_a, fm_b, fm_p;

    always_comb begin
        fm_a = is_signed_op ? {{XLEN{opr1[XLEN-1]}}, opr1} : {{XLEN{1'b0}}, opr1};
        fm_b = is_signed_op ? {{XLEN{opr2[XLEN-1]}}, opr2} : {{XLEN{1'b0}}, opr2};
        // Product of the extended operands, taken mod 2^(2*XLEN), is the
        // exact signed or unsigned full product.
        fm_p = fm_a * fm_b;
    end
`endif

    // ------------------------------------------------------ iteration step
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_shift;
    logic [XLEN-1:0]   div_diff;
    logic              div_ge;
    logic [XLEN-1:0]   step_hi, step_lo;
    logic [2*XLEN-1:0] prod_mag, prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix;

    always_comb begin
        // Multiply: add multiplicand when the current multiplier bit is set,
        // then shift {carry, hi, lo} right by one. lo fills with product bits.
        mul_sum   = {1'b0, acc_hi_q} + ({1'b0, mcand_q} & {(XLEN+1){acc_lo_q[0]}});
        // Divide: bring the next dividend bit into the remainder, subtract the
        // divisor if it fits. The remainder stays below the divisor, so the
        // low XLEN bits of the difference are exact when it fits.
        div_shift = {acc_hi_q, acc_lo_q[XLEN-1]};
        div_ge    = (div_shift >= {1'b0, mcand_q});
        div_diff  = div_shift[XLEN-1:0] - mcand_q;

        if (is_div_q) begin
            step_hi = div_ge ? div_diff : div_shift[XLEN-1:0];
            step_lo = {acc_lo_q[XLEN-2:0], div_ge};
        end else begin
            step_hi = mul_sum[XLEN:1];
            step_lo = {mul_sum[0], acc_lo_q[XLEN-1:1]};
        end

        prod_mag = {step_hi, step_lo};
        prod_fix = neg_res_q ? -prod_mag : prod_mag;
        // MIN / -1 needs no special case: |MIN| = MIN, and negating MIN
        // again yields MIN with a zero remainder.
        quo_fix  = neg_res_q ? -step_lo : step_lo;
        rem_fix  = neg_rem_q ? -step_hi : step_hi;
    end

    // --------------------------------------------------------- next state
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        dbz_d     = dbz_q;
        dvd_d     = dvd_q;
        acc_hi_d  = acc_hi_q;
        acc_lo_d  = acc_lo_q;
        mcand_d   = mcand_q;
        res_d     = res_q;
        res_hi_d  = res_hi_q;

        if (flush) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        cnt_d     = '0;
                        is_div_d  = is_div_op;
                        neg_res_d = a_neg ^ b_neg;
                        neg_rem_d = a_neg;
                        dbz_d     = (opr2 == '0);
                        dvd_d     = opr1;
                        if (is_div_op) begin
                            acc_hi_d = '0;
                            acc_lo_d = a_mag;
                            mcand_d  = b_mag;
                            state_d  = ST_BUSY;
                        end else if (is_muldiv) begin
`ifdef ALU_MC_FAST_MUL_EN
                            res_d    = fm_p[XLEN-1:0];
                            res_hi_d = fm_p[2*XLEN-1:XLEN];
                            state_d  = ST_DONE;
`else
                            acc_hi_d = '0;
                            acc_lo_d = b_mag;
                            mcand_d  = a_mag;
                            state_d  = ST_BUSY;
`endif
                        end else begin
                            res_d    = simple_res;
                            res_hi_d = '0;
                            state_d  = ST_DONE;
                        end
                    end
                end
                ST_BUSY: begin
                    acc_hi_d = step_hi;
                    acc_lo_d = step_lo;
                    cnt_d    = cnt_q + SHW'(1);
                    if (cnt_q == CNT_LAST) begin
                        state_d = ST_DONE;
                        cnt_d   = '0;
                        if (!is_div_q) begin
                            res_d    = prod_fix[XLEN-1:0];
                            res_hi_d = prod_fix[2*XLEN-1:XLEN];
                        end else if (dbz_q) begin
                            res_d    = '1;
                            res_hi_d = dvd_q;
                        end else begin
                            res_d    = quo_fix;
                            res_hi_d = rem_fix;
                        end
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dbz_q     <= 1'b0;
            dvd_q     <= '0;
            acc_hi_q  <= '0;
            acc_lo_q  <= '0;
            mcand_q   <= '0;
            res_q     <= '0;
            res_hi_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            dbz_q     <= dbz_d;
            dvd_q     <= dvd_d;
            acc_hi_q  <= acc_hi_d;
            acc_lo_q  <= acc_lo_d;
            mcand_q   <= mcand_d;
            res_q     <= res_d;
            res_hi_q  <= res_hi_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q == ST_BUSY);
    assign res       = res_q;
    assign res_hi    = res_hi_q;

endmodule

// File: tb/tb_alu_mc.sv
// -----------------------------------------------------------------------------
// tb_alu_mc -- scoreboard bench for alu_mc. The stimulus side pushes the
// expected {res_hi,res} and latency on each accept; a monitor on the falling
// edge checks wait-cycle outputs, latency and result, and pops on retire.
// -----------------------------------------------------------------------------
module tb_alu_mc;
    localparam int XLEN = 32;
    localparam int W2   = 2 * XLEN;
`ifdef ALU_MC_FAST_MUL_EN
    localparam bit FAST_MUL = 1'b1;
`else
    localparam bit FAST_MUL = 1'b0;
`endif
    localparam logic [XLEN-1:0] MIN  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ONES = '1;

    logic            clk = 1'b0;
    logic            resetn, flush, in_valid, in_ready, out_valid, out_ready, busy;
    logic [3:0]      op;
    logic [XLEN-1:0] opr1, opr2, res, res_hi;

    alu_mc #(.XLEN(XLEN)) dut (
        .clk(clk), .resetn(resetn), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .opr1(opr1), .opr2(opr2),
        .out_valid(out_valid), .out_ready(out_ready),
        .res(res), .res_hi(res_hi), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]    op;
        logic [W2-1:0] exp;
        int            lat;
        int            acc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   rdy_mode = 0;   // 0: always ready, 1: random, 2: held low
    bit   front_seen = 1'b0;
    bit   just_retired = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [W2-1:0] act, input logic [W2-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: plain arithmetic on the operation's definition.
    function automatic logic [W2-1:0] model(input logic [3:0] o, input logic [XLEN-1:0] a,
                                             input logic [XLEN-1:0] b);
        logic signed [W2-1:0] sa, sb2, p, q, r;
        logic [XLEN-1:0] lo;
        int amt;
        sa  = {{XLEN{a[XLEN-1]}}, a};
        sb2 = {{XLEN{b[XLEN-1]}}, b};
        amt = int'(a % XLEN);
        lo  = '0;
        case (o)
            4'd0:  lo = a + b;
            4'd1:  lo = a - b;
            4'd2:  lo = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            4'd3:  lo = {{(XLEN-1){1'b0}}, (a < b)};
            4'd4:  lo = a & b;
            4'd5:  lo = ~(a | b);
            4'd6:  lo = a | b;
            4'd7:  lo = a ^ b;
            4'd8:  lo = b << amt;
            4'd9:  lo = b >> amt;
            4'd10: lo = $signed(b) >>> amt;
            4'd11: lo = b << (XLEN / 2);
            4'd12: begin p = sa * sb2; return p; end
            4'd13: return {{XLEN{1'b0}}, a} * {{XLEN{1'b0}}, b};
            4'd14: begin
                if (b == '0) return {a, ONES};
                if (a == MIN && b == ONES) return {{XLEN{1'b0}}, MIN};
                q = sa / sb2;
                r = sa % sb2;
                return {r[XLEN-1:0], q[XLEN-1:0]};
            end
            default: begin
                if (b == '0) return {a, ONES};
                return {a % b, a / b};
            end
        endcase
        return {{XLEN{1'b0}}, lo};
    endfunction

    function automatic int lat_of(input logic [3:0] o);
        if (o >= 4'd14) return XLEN + 1;
        if (o >= 4'd12) return FAST_MUL ? 1 : XLEN + 1;
        return 1;
    endfunction

    function automatic logic [XLEN-1:0] rnd();
        logic [63:0] r;
        r = {$urandom, $urandom};
        case ($urandom_range(0, 6))
            0:       return '0;
            1:       return ONES;
            2:       return MIN;
            3:       return XLEN'($urandom_range(0, 9));
            4:       return -XLEN'($urandom_range(1, 9));
            default: return r[XLEN-1:0];
        endcase
    endfunction

    // ------------------------------------------------------------- monitor
    always @(negedge clk) begin
        int since;
        if (!resetn) begin
            front_seen   = 1'b0;
            just_retired = 1'b0;
        end else begin
            if (just_retired) begin
                chk("in_ready_after_retire", W2'(in_ready), W2'(1));
                just_retired = 1'b0;
            end
            if (sb.size() == 0) begin
                if (out_valid) chk("unexpected_out_valid", W2'(out_valid), W2'(0));
            end else begin
                since = cyc - sb[0].acc;
                if (since >= 1) begin
                    if (!out_valid) begin
                        if (since >= sb[0].lat) begin
                            chk("out_valid_at_latency", W2'(out_valid), W2'(1));
                        end else begin
                            chk("busy_while_iterating", W2'(busy), W2'(sb[0].lat > 1));
                            chk("in_ready_while_iterating", W2'(in_ready), W2'(0));
                        end
                    end else begin
                        if (!front_seen) begin
                            chk("latency", W2'(since), W2'(sb[0].lat));
                            front_seen = 1'b1;
                        end
                        chk("result", {res_hi, res}, sb[0].exp);
                        chk("in_ready_while_valid", W2'(in_ready), W2'(0));
                        chk("busy_while_valid", W2'(busy), W2'(0));
                        if (out_ready) begin
                            $display("retire op=%0d res_hi=%h res=%h", sb[0].op, res_hi, res);
                            void'(sb.pop_front());
                            front_seen   = 1'b0;
                            just_retired = 1'b1;
                        end
                    end
                end
            end
        end
    end

    // ---------------------------------------------------------- out_ready
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b0;
            endcase
        end
    end

    // ------------------------------------------------------------ driver
    task automatic issue(input logic [3:0] o, input logic [XLEN-1:0] a,
                         input logic [XLEN-1:0] b, input logic [W2-1:0] e);
        exp_t it;
        bit   ok;
        ok = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        op       = o;
        opr1     = a;
        opr2     = b;
        for (int t = 0; t < 4 * XLEN + 50; t++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            chk("in_ready_timeout", W2'(in_ready), W2'(1));
        end else begin
            it.op  = o;
            it.exp = e;
            it.lat = lat_of(o);
            it.acc = cyc;
            sb.push_back(it);
            @(posedge clk);
            #1;
        end
        // Scramble inputs after accept: the unit must have latched them.
        in_valid = 1'b0;
        op       = 4'($urandom_range(0, 15));
        opr1     = rnd();
        opr2     = rnd();
    endtask

    task automatic drain();
        for (int t = 0; t < 4 * XLEN + 50 && sb.size() != 0; t++) @(negedge clk);
        if (sb.size() != 0) begin
            chk("drain_timeout", W2'(sb.size()), W2'(0));
            sb.delete();
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]      o;
        logic [XLEN-1:0] a, b, lui_imm;
        int              cnt_ov;

        resetn   = 1'b0;
        flush    = 1'b0;
        in_valid = 1'b0;
        op       = '0;
        opr1     = '0;
        opr2     = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_out_valid", W2'(out_valid), W2'(0));
        chk("reset_busy", W2'(busy), W2'(0));
        chk("reset_res", W2'(res), W2'(0));
        chk("reset_res_hi", W2'(res_hi), W2'(0));
        chk("reset_in_ready", W2'(in_ready), W2'(1));
        @(posedge clk);
        #1 resetn = 1'b1;
        @(negedge clk);
        chk("in_ready_after_release", W2'(in_ready), W2'(1));

        // Directed cases with hand-derived expectations.
        lui_imm = XLEN'(16'h1234);
        issue(4'd0,  ONES, XLEN'(1), '0);
        drain();
        issue(4'd1,  '0, XLEN'(1), {{XLEN{1'b0}}, ONES});
        drain();
        issue(4'd2,  MIN, XLEN'(1), W2'(1));
        drain();
        issue(4'd3,  MIN, XLEN'(1), '0);
        drain();
        issue(4'd10, XLEN'(4), MIN, {{XLEN{1'b0}}, ~(ONES >> 5)});
        drain();
        issue(4'd11, '0, lui_imm, {{XLEN{1'b0}}, lui_imm << (XLEN / 2)});
        drain();
        issue(4'd8,  XLEN'(3), XLEN'(1), W2'(8));
        drain();
        issue(4'd12, XLEN'(-3), XLEN'(5), W2'(-15));
        drain();
        issue(4'd13, ONES, ONES, {ONES - XLEN'(1), XLEN'(1)});
        drain();
        issue(4'd14, XLEN'(-7), XLEN'(2), {ONES, XLEN'(-3)});
        drain();
        issue(4'd15, XLEN'(7), '0, {XLEN'(7), ONES});
        drain();
        issue(4'd14, MIN, ONES, {{XLEN{1'b0}}, MIN});
        drain();

        // Backpressure: result held for several cycles before retire.
        rdy_mode = 2;
        @(posedge clk);
        issue(4'd4, XLEN'(32'hF0F0_A5A5), XLEN'(32'h0FF0_FFFF),
              {{XLEN{1'b0}}, XLEN'(32'hF0F0_A5A5) & XLEN'(32'h0FF0_FFFF)});
        for (int t = 0; t < 10 && !out_valid; t++) @(negedge clk);
        repeat (5) @(negedge clk);
        rdy_mode = 0;
        drain();

        // Flush in the tenth busy cycle of a DIVU.
        issue(4'd15, XLEN'(100), XLEN'(7), {XLEN'(2), XLEN'(14)});
        repeat (9) @(posedge clk);
        #1 flush = 1'b1;
        sb.delete();
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        chk("flush_in_ready", W2'(in_ready), W2'(1));
        chk("flush_busy", W2'(busy), W2'(0));
        chk("flush_out_valid", W2'(out_valid), W2'(0));
        cnt_ov = 0;
        for (int t = 0; t < 2 * XLEN; t++) begin
            @(negedge clk);
            if (out_valid) cnt_ov++;
        end
        chk("flush_no_result", W2'(cnt_ov), W2'(0));

        // Reset in the middle of a DIV.
        issue(4'd14, XLEN'(-100), XLEN'(7), model(4'd14, XLEN'(-100), XLEN'(7)));
        repeat (5) @(posedge clk);
        #1 resetn = 1'b0;
        sb.delete();
        @(posedge clk);
        @(negedge clk);
        chk("midop_reset_out_valid", W2'(out_valid), W2'(0));
        chk("midop_reset_busy", W2'(busy), W2'(0));
        chk("midop_reset_res", {res_hi, res}, '0);
        chk("midop_reset_in_ready", W2'(in_ready), W2'(1));
        @(posedge clk);
        #1 resetn = 1'b1;

        // Randomised ops against the reference model with random backpressure.
        rdy_mode = 1;
        repeat (150) begin
            o = 4'($urandom_range(0, 15));
            a = rnd();
            b = rnd();
            issue(o, a, b, model(o, a, b));
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
        end
        rdy_mode = 0;
        drain();
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
